// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// hazard_controller : stall/flush/nop sequencer for the five-stage pipeline.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
// Revision: 1.0
// ============================================================================
module hazard_controller #(
  parameter int REG_ADDR_WIDTH    = 5,
  parameter int INIT_FLUSH_CYCLES = 4,
  parameter int MAX_WAIT          = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic                      id_uses_rt,
  input  logic                      ex_mem_read,
  input  logic [REG_ADDR_WIDTH-1:0] ex_reg_dst,
  input  logic                      ex_mispredict,
  input  logic                      mem_req,
  input  logic                      dmem_ready,
  input  logic                      imem_ready,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      id_ex_stall,
  output logic                      ex_mem_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_flush,
  output logic                      ex_mem_flush,
  output logic                      mem_wb_flush,
  output logic                      pipe_nop,
  output logic                      mem_timeout
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]               stall_count,
  output logic [31:0]               flush_count
`endif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int INIT_W = $clog2(INIT_FLUSH_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(INIT_FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_HALT     = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                mem_timeout_q, mem_timeout_d;
  logic                w_run_decode;
  logic                w_load_use;

  // Register 0 is hardwired, so a load targeting it can never create a hazard.
  assign w_load_use = ex_mem_read && (ex_reg_dst != '0) &&
                      ((ex_reg_dst == id_rs) || (id_uses_rt && (ex_reg_dst == id_rt)));

  assign mem_timeout = mem_timeout_q;

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    w_run_decode  = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    id_ex_stall   = 1'b0;
    ex_mem_stall  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    mem_wb_flush  = 1'b0;
    pipe_nop      = 1'b0;

    case (state_q)
      S_INIT: begin
        pc_stall     = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_flush = 1'b1;
        mem_wb_flush = 1'b1;
        if (init_cnt_q == INIT_LAST) begin
          state_d    = S_RUN;
          init_cnt_d = '0;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (mem_req && !dmem_ready) begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
          state_d      = S_MEM_WAIT;
          wait_cnt_d   = WAIT_W'(1);
        end else begin
          w_run_decode = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ready) begin
          w_run_decode = 1'b1;
          state_d      = S_RUN;
          wait_cnt_d   = '0;
        end else begin
          pc_stall     = 1'b1;
          if_id_stall  = 1'b1;
          id_ex_stall  = 1'b1;
          ex_mem_stall = 1'b1;
          mem_wb_flush = 1'b1;
          if (wait_cnt_q == WAIT_MAX) begin
            state_d       = S_HALT;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
        pipe_nop     = 1'b1;
      end
    endcase

    // Shared by RUN and the MEM_WAIT release cycle; the memory condition is already excluded.
    if (w_run_decode) begin
      if (ex_mispredict) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_INIT;
      init_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count_q;
  logic [31:0] flush_count_q;
  logic        w_stall_evt;
  logic        w_flush_evt;

  assign w_stall_evt = pc_stall && ((state_q == S_RUN) || (state_q == S_MEM_WAIT));
  assign w_flush_evt = w_run_decode && ex_mispredict;
  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
      flush_count_q <= '0;
    end else begin
      if (w_stall_evt && (stall_count_q != 32'hFFFF_FFFF)) stall_count_q <= stall_count_q + 32'd1;
      if (w_flush_evt && (flush_count_q != 32'hFFFF_FFFF)) flush_count_q <= flush_count_q + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// tb_hazard_controller : directed self-checking bench for hazard_controller.
// Revision: 1.0
// ============================================================================
module tb_hazard_controller;

  localparam int RW = 5;
  // {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
  //  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pipe_nop}
  localparam logic [8:0] E_IDLE = 9'b000000000;
  localparam logic [8:0] E_INIT = 9'b100011110;
  localparam logic [8:0] E_LU   = 9'b110001000;
  localparam logic [8:0] E_MISP = 9'b000011000;
  localparam logic [8:0] E_MEM  = 9'b111100010;
  localparam logic [8:0] E_HALT = 9'b111100011;
  localparam logic [8:0] E_IMEM = 9'b100010000;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, ex_reg_dst;
  logic          id_uses_rt, ex_mem_read, ex_mispredict, mem_req, dmem_ready, imem_ready;
  logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pipe_nop, mem_timeout;
`ifdef HAZARD_STATS_EN
  logic [31:0]   stall_count, flush_count;
`endif
  logic [8:0]    outs;
  int            checks = 0;
  int            errors = 0;

  assign outs = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                 if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pipe_nop};

  always #5 clk = ~clk;

  hazard_controller #(.REG_ADDR_WIDTH(RW), .INIT_FLUSH_CYCLES(4), .MAX_WAIT(15)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_reg_dst(ex_reg_dst), .ex_mispredict(ex_mispredict),
    .mem_req(mem_req), .dmem_ready(dmem_ready), .imem_ready(imem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush), .pipe_nop(pipe_nop),
    .mem_timeout(mem_timeout)
`ifdef HAZARD_STATS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_reg_dst = '0;
    ex_mispredict = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1; imem_ready = 1'b1;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Assert reset, check INIT decode, release, check the INIT_FLUSH_CYCLES flush window.
  task automatic test_reset();
    cyc(); idle(); reset = 1'b1; #1;
    checks++;
    if (outs !== E_INIT || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_hold: outs=%b timeout=%b required %b/0", outs, mem_timeout, E_INIT);
    end
    cyc(); reset = 1'b0; #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (outs !== E_INIT) begin
        errors++; $display("FAIL init_window[%0d]: outs=%b required %b", i, outs, E_INIT);
      end
      cyc(); #1;
    end
    checks++;
    if (outs !== E_IDLE) begin
      errors++; $display("FAIL run_idle: outs=%b required %b", outs, E_IDLE);
    end
  endtask

  task automatic test_load_use();
    cyc(); idle(); ex_mem_read = 1'b1; ex_reg_dst = 5'd3; id_rs = 5'd3; #1;
    checks++;
    if (outs !== E_LU) begin
      errors++; $display("FAIL load_use_rs: outs=%b required %b", outs, E_LU);
    end
    cyc(); idle(); #1;
    checks++;
    if (outs !== E_IDLE) begin
      errors++; $display("FAIL load_use_one_cycle: outs=%b required %b", outs, E_IDLE);
    end
    cyc(); idle(); ex_mem_read = 1'b1; ex_reg_dst = 5'd0; id_rs = 5'd0; #1;
    checks++;
    if (outs !== E_IDLE) begin
      errors++; $display("FAIL load_use_r0: outs=%b required %b", outs, E_IDLE);
    end
    cyc(); idle(); ex_mem_read = 1'b1; ex_reg_dst = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b1; #1;
    checks++;
    if (outs !== E_LU) begin
      errors++; $display("FAIL load_use_rt: outs=%b required %b", outs, E_LU);
    end
    id_uses_rt = 1'b0; #1;
    checks++;
    if (outs !== E_IDLE) begin
      errors++; $display("FAIL load_use_rt_unused: outs=%b required %b", outs, E_IDLE);
    end
    ex_mem_read = 1'b0; id_uses_rt = 1'b1; #1;
    checks++;
    if (outs !== E_IDLE) begin
      errors++; $display("FAIL not_a_load: outs=%b required %b", outs, E_IDLE);
    end
  endtask

  task automatic test_priority();
    cyc(); idle(); ex_mispredict = 1'b1; ex_mem_read = 1'b1; ex_reg_dst = 5'd4; id_rs = 5'd4; imem_ready = 1'b0; #1;
    checks++;
    if (outs !== E_MISP) begin
      errors++; $display("FAIL misp_over_all: outs=%b required %b", outs, E_MISP);
    end
    ex_mispredict = 1'b0; #1;
    checks++;
    if (outs !== E_LU) begin
      errors++; $display("FAIL lu_over_imem: outs=%b required %b", outs, E_LU);
    end
    ex_mem_read = 1'b0; #1;
    checks++;
    if (outs !== E_IMEM) begin
      errors++; $display("FAIL imem_wait: outs=%b required %b", outs, E_IMEM);
    end
  endtask

  // Three dmem wait cycles with a mispredict pending; the release cycle flushes.
  task automatic test_mem_wait();
    cyc(); idle(); mem_req = 1'b1; dmem_ready = 1'b0; ex_mispredict = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        ex_mem_read = 1'b1; ex_reg_dst = 5'd9; id_rs = 5'd9; imem_ready = 1'b0; #1;
      end
      checks++;
      if (outs !== E_MEM) begin
        errors++; $display("FAIL mem_wait[%0d]: outs=%b required %b", i, outs, E_MEM);
      end
      cyc();
      ex_mem_read = 1'b0; imem_ready = 1'b1; #1;
    end
    dmem_ready = 1'b1; #1;
    checks++;
    if (outs !== E_MISP) begin
      errors++; $display("FAIL mem_release: outs=%b required %b", outs, E_MISP);
    end
    cyc(); idle(); #1;
    checks++;
    if (outs !== E_IDLE) begin
      errors++; $display("FAIL after_release: outs=%b required %b", outs, E_IDLE);
    end
  endtask

  task automatic test_timeout();
    cyc(); idle(); mem_req = 1'b1; dmem_ready = 1'b0; #1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (outs !== E_MEM || mem_timeout !== 1'b0) begin
        errors++; $display("FAIL wait_before_timeout[%0d]: outs=%b timeout=%b required %b/0", i, outs, mem_timeout, E_MEM);
      end
      cyc(); #1;
    end
    checks++;
    if (outs !== E_HALT || mem_timeout !== 1'b1) begin
      errors++; $display("FAIL halt_entry: outs=%b timeout=%b required %b/1", outs, mem_timeout, E_HALT);
    end
    idle(); ex_mispredict = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      checks++;
      if (outs !== E_HALT || mem_timeout !== 1'b1) begin
        errors++; $display("FAIL halt_sticky[%0d]: outs=%b timeout=%b required %b/1", i, outs, mem_timeout, E_HALT);
      end
    end
    idle(); reset = 1'b1; #1;
    checks++;
    if (outs !== E_INIT || mem_timeout !== 1'b0) begin
      errors++; $display("FAIL reset_from_halt: outs=%b timeout=%b required %b/0", outs, mem_timeout, E_INIT);
    end
    cyc(); reset = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    #1;
    checks++;
    if (outs !== E_IDLE) begin
      errors++; $display("FAIL run_after_halt_reset: outs=%b required %b", outs, E_IDLE);
    end
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    checks++;
    if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
      errors++; $display("FAIL stats_reset: stall=%0d flush=%0d required 0/0", stall_count, flush_count);
    end
    for (int i = 0; i < 2; i++) begin
      cyc(); idle(); ex_mem_read = 1'b1; ex_reg_dst = 5'd2; id_rs = 5'd2;
      cyc(); idle();
    end
    cyc(); idle(); ex_mispredict = 1'b1;
    cyc(); idle(); #1;
    checks++;
    if (stall_count !== 32'd2 || flush_count !== 32'd1) begin
      errors++; $display("FAIL stats_counts: stall=%0d flush=%0d required 2/1", stall_count, flush_count);
    end
  endtask
`endif

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_load_use();
    test_priority();
    test_mem_wait();
    test_timeout();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
